nes_video_timing: RTL

// - Raster timing generator and frame-buffer fetch sequencer feeding the three tmds_encoder channels.
// - Scans the 640x480@60 DVI raster and requests NES pixels (256x240, 2x scaled to a 512x480 window).
// - Emits border colour outside the window and aligns RGB, data_en, hsync and vsync to one latency.

---
 rtl/nes_video_timing_pkg.sv | 32 +++
 rtl/sig_delay.sv | 40 ++++
 rtl/nes_video_timing.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/nes_video_timing_pkg.sv
// Shared raster constants for the 640x480@60 DVI timing and the 2x-scaled NES window.
// Also holds the pipeline stage record that travels alongside frame-buffer reads.
package nes_video_timing_pkg;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam logic SYNC_ACTIVE_LOW = 1'b0;

   localparam int NES_WIN_W = 512;
   localparam int NES_WIN_H = 480;

   typedef struct packed {
      logic frame;
      logic win;
      logic vis;
      logic vs;
      logic hs;
   } stage_t;

   // Raster offset inside the window maps to an NES coordinate by halving.
   function automatic logic [7:0] nes_coord(input logic [10:0] rel);
      return 8'(rel >> 1);
   endfunction

endpackage

// File: rtl/sig_delay.sv
// Synchronously reset shift register; DEPTH=0 degenerates to a wire.
module sig_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (DEPTH == 0) begin : g_pass
      assign dout = din;
   end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      // next value of each stage is its upstream neighbour
      always_comb begin
         stage_d[0] = din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end

      // stage registers, cleared to inactive on reset
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
               stage_q[i] <= '0;
            end
         end else begin
            stage_q <= stage_d;
         end
      end

      assign dout = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/nes_video_timing.sv
// 640x480 DVI raster generator that fetches a 256x240 NES image as a 2x-scaled window.
// RGB, data_en, syncs and frame_start all leave the block FB_LATENCY+2 cycles after the counters.
module nes_video_timing
   import nes_video_timing_pkg::*;
#(
   parameter int          H_VISIBLE  = DEF_H_VISIBLE,
   parameter int          H_FRONT    = DEF_H_FRONT,
   parameter int          H_SYNC     = DEF_H_SYNC,
   parameter int          H_BACK     = DEF_H_BACK,
   parameter int          V_VISIBLE  = DEF_V_VISIBLE,
   parameter int          V_FRONT    = DEF_V_FRONT,
   parameter int          V_SYNC     = DEF_V_SYNC,
   parameter int          V_BACK     = DEF_V_BACK,
   parameter logic        HSYNC_POL  = SYNC_ACTIVE_LOW,
   parameter logic        VSYNC_POL  = SYNC_ACTIVE_LOW,
   parameter int          WIN_X      = 64,
   parameter int          WIN_Y      = 0,
   parameter int          FB_LATENCY = 2,
   parameter logic [23:0] BORDER_RGB = 24'h000000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        fb_rd_en,
   output logic [7:0]  fb_rd_x,
   output logic [7:0]  fb_rd_y,
   input  logic [23:0] fb_rgb,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        data_en,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   if ((WIN_X + NES_WIN_W > H_VISIBLE) || (WIN_Y + NES_WIN_H > V_VISIBLE)) begin : g_bad_window
      $error("nes_video_timing: NES window does not fit inside the visible raster");
   end
   if ((FB_LATENCY < 0) || (FB_LATENCY > 8)) begin : g_bad_latency
      $error("nes_video_timing: FB_LATENCY must be within 0..8");
   end

   logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [10:0] h_rel_s, v_rel_s;
   stage_t      stage_s, stage_dly_s;
   logic        fb_rd_en_q, fb_rd_en_d;
   logic [7:0]  fb_rd_x_q, fb_rd_x_d, fb_rd_y_q, fb_rd_y_d;
   logic [23:0] rgb_q, rgb_d;
   logic        data_en_q, data_en_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic        frame_start_q, frame_start_d;

   // raster counters: h wraps every line, v advances on the h wrap
   always_comb begin
      h_cnt_d = h_cnt_q + 11'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = 11'd0;
         if (v_cnt_q == V_LAST) begin
            v_cnt_d = 11'd0;
         end else begin
            v_cnt_d = v_cnt_q + 11'd1;
         end
      end else begin
         h_cnt_d = h_cnt_q + 11'd1;
      end
   end

   // Offsets wrap to large values left of / above the window, so one compare bounds each axis.
   assign h_rel_s = h_cnt_q - 11'(WIN_X);
   assign v_rel_s = v_cnt_q - 11'(WIN_Y);

   // stage-0 decode and the frame-buffer request that goes with it
   always_comb begin
      stage_s.vis   = (h_cnt_q < 11'(H_VISIBLE)) && (v_cnt_q < 11'(V_VISIBLE));
      stage_s.hs    = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
      stage_s.vs    = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
      stage_s.win   = (h_rel_s < 11'(NES_WIN_W)) && (v_rel_s < 11'(NES_WIN_H));
      stage_s.frame = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
      fb_rd_en_d    = stage_s.win;
      if (stage_s.win) begin
         fb_rd_x_d = nes_coord(h_rel_s);
         fb_rd_y_d = nes_coord(v_rel_s);
      end else begin
         fb_rd_x_d = 8'd0;
         fb_rd_y_d = 8'd0;
      end
   end

   // Stage flags emerge in the same cycle as the fb_rgb answering their request.
   sig_delay #(
      .WIDTH ($bits(stage_t)),
      .DEPTH (FB_LATENCY + 1)
   ) u_align (
      .clk  (clk),
      .rst  (rst),
      .din  (stage_s),
      .dout (stage_dly_s)
   );

   // output pixel select and sync levels
   always_comb begin
      if (stage_dly_s.win) begin
         rgb_d = fb_rgb;
      end else if (stage_dly_s.vis) begin
         rgb_d = BORDER_RGB;
      end else begin
         rgb_d = 24'h000000;
      end
      data_en_d     = stage_dly_s.vis;
      hsync_d       = stage_dly_s.hs ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = stage_dly_s.vs ? VSYNC_POL : ~VSYNC_POL;
      frame_start_d = stage_dly_s.frame;
   end

   // counter, request and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_q       <= 11'd0;
         v_cnt_q       <= 11'd0;
         fb_rd_en_q    <= 1'b0;
         fb_rd_x_q     <= 8'd0;
         fb_rd_y_q     <= 8'd0;
         rgb_q         <= 24'h000000;
         data_en_q     <= 1'b0;
         hsync_q       <= ~HSYNC_POL;
         vsync_q       <= ~VSYNC_POL;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         fb_rd_en_q    <= fb_rd_en_d;
         fb_rd_x_q     <= fb_rd_x_d;
         fb_rd_y_q     <= fb_rd_y_d;
         rgb_q         <= rgb_d;
         data_en_q     <= data_en_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign fb_rd_en    = fb_rd_en_q;
   assign fb_rd_x     = fb_rd_x_q;
   assign fb_rd_y     = fb_rd_y_q;
   assign red         = rgb_q[23:16];
   assign green       = rgb_q[15:8];
   assign blue        = rgb_q[7:0];
   assign data_en     = data_en_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = frame_start_q;

endmodule
